// File: rtl/batch_reverse_buffer_pkg.sv
// Shared helpers for the batch reverse buffer slice.
package batch_reverse_buffer_pkg;

  // Width of an in-batch index for a batch of `depth` samples.
  function automatic int idx_w(input int depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

endpackage

// File: rtl/batch_reverse_buffer_if.sv
// Sample-in / reversed-sample-out bundle of the batch reverse buffer.
interface batch_reverse_buffer_if
  import batch_reverse_buffer_pkg::*;
#(
  parameter int N      = 3,
  parameter int stages = 32
);
  localparam int IW = idx_w(stages);

  logic [N-1:0]  in;
  logic          in_valid;
  logic [N-1:0]  out;
  logic          out_valid;
  logic          out_first;
  logic          out_last;
  logic [IW-1:0] batch_idx;

  // Producer side: drives samples, observes the replay.
  modport master (
    output in, in_valid,
    input  out, out_valid, out_first, out_last, batch_idx
  );

  // Buffer side.
  modport slave (
    input  in, in_valid,
    output out, out_valid, out_first, out_last, batch_idx
  );
endinterface

// File: rtl/batch_reverse_buffer_batch_ram.sv
// Two-bank, one-write/one-read synchronous RAM. The registered read port is
// the block's output register, so it carries the asynchronous clear.
module batch_ram
  import batch_reverse_buffer_pkg::*;
#(
  parameter int N      = 3,
  parameter int stages = 32
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      we,
  input  logic                      wbank,
  input  logic [idx_w(stages)-1:0]  widx,
  input  logic [N-1:0]              wdata,
  input  logic                      re,
  input  logic                      rbank,
  input  logic [idx_w(stages)-1:0]  ridx,
  output logic [N-1:0]              rdata
);
  localparam int IW = idx_w(stages);

  logic [N-1:0] mem [0:2*stages-1];

  // Write port: contents are never reset.
  always_ff @(posedge clk) begin
    if (we) mem[{wbank, widx}] <= wdata;
  end

  // Registered read port, cleared by reset, holds when not reading.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)     rdata <= '0;
    else if (re) rdata <= mem[{rbank, ridx}];
  end
endmodule

// File: rtl/batch_reverse_buffer.sv
// Collects control-bit samples into batches of `stages` using ping-pong
// banks and replays each completed batch in reverse order, one per clock.
module batch_reverse_buffer
  import batch_reverse_buffer_pkg::*;
#(
  parameter int N      = 3,
  parameter int stages = 32
) (
  input  logic                 clk,
  input  logic                 rst,
  batch_reverse_buffer_if.slave bus
);
  localparam int IW = idx_w(stages);
  localparam logic [IW-1:0] LAST_IDX = IW'(stages - 1);

  typedef enum logic {R_IDLE, R_PLAY} rstate_t;

  logic [IW-1:0] wr_idx;
  logic          wb;
  logic          swap;

  rstate_t       state;
  logic [IW-1:0] rd_idx;
  logic          rb;

  // A write into the final slot completes the batch and flips the banks.
  assign swap = bus.in_valid && (wr_idx == LAST_IDX);

  // Write side: fill the current bank, toggle bank when a batch completes.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_idx <= '0;
      wb     <= 1'b0;
    end else if (bus.in_valid) begin
      wr_idx <= wr_idx + 1'b1;
      if (swap) wb <= ~wb;
    end
  end

  // Read FSM: walk the handed-over bank from the top index down to zero;
  // a swap landing on the final read reloads without a bubble.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state         <= R_IDLE;
      rd_idx        <= '0;
      rb            <= 1'b0;
      bus.out_valid <= 1'b0;
      bus.out_first <= 1'b0;
      bus.out_last  <= 1'b0;
      bus.batch_idx <= '0;
    end else begin
      case (state)
        R_IDLE: begin
          bus.out_valid <= 1'b0;
          bus.out_first <= 1'b0;
          bus.out_last  <= 1'b0;
          if (swap) begin
            state  <= R_PLAY;
            rd_idx <= LAST_IDX;
            rb     <= wb;
          end
        end
        R_PLAY: begin
          bus.out_valid <= 1'b1;
          bus.out_first <= (rd_idx == LAST_IDX);
          bus.out_last  <= (rd_idx == '0);
          bus.batch_idx <= rd_idx;
          rd_idx        <= rd_idx - 1'b1;
          if (rd_idx == '0) begin
            if (swap) begin
              rd_idx <= LAST_IDX;
              rb     <= wb;
            end else begin
              state <= R_IDLE;
            end
          end
        end
        default: state <= R_IDLE;
      endcase
    end
  end

  batch_ram #(.N(N), .stages(stages)) u_ram (
    .clk   (clk),
    .rst   (rst),
    .we    (bus.in_valid),
    .wbank (wb),
    .widx  (wr_idx),
    .wdata (bus.in),
    .re    (state == R_PLAY),
    .rbank (rb),
    .ridx  (rd_idx),
    .rdata (bus.out)
  );
endmodule
